prefetch_fifo_bank: RTL and testbench

Parametrised multi-channel prefetch buffer between the SDRAM controller's burst-fill path and the per-accelerator Wishbone read path. Each channel is a circular FIFO: it fills from SDRAM burst beats and drains one word per hit. Each channel also provides full/empty/occupancy status, flush, and sticky overflow/underflow error flags. It replaces the fixed 3×8 shift-register buffer with a pointer-based design: DW bits wide, DEPTH deep, NCH channels.

---
 rtl/prefetch_fifo_bank.sv | 139 +++++++++++++
 tb/tb_prefetch_fifo_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fifo_bank.sv
// Multi-channel circular prefetch FIFO bank: SDRAM burst beats fill per-channel
// FIFOs, prioritised hits drain one registered word per cycle.
module prefetch_fifo_bank #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NCH   = 3,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CNTW = AW + 1,
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      fill_valid,
  input  logic [DW-1:0]       fill_data,
  input  logic [NCH-1:0]      hit,
  input  logic [NCH-1:0]      flush,
  output logic [DW-1:0]       data_out,
  output logic                data_valid,
  output logic [CW-1:0]       data_ch,
  output logic [NCH-1:0]      full,
  output logic [NCH-1:0]      empty,
  output logic [NCH*CNTW-1:0] count,
  output logic [NCH-1:0]      ovf_err,
  output logic [NCH-1:0]      udf_err
);

  logic [DW-1:0]   mem_q      [NCH][DEPTH];
  logic [AW-1:0]   wr_ptr_q   [NCH];
  logic [AW-1:0]   wr_ptr_d   [NCH];
  logic [AW-1:0]   rd_ptr_q   [NCH];
  logic [AW-1:0]   rd_ptr_d   [NCH];
  logic [CNTW-1:0] count_q    [NCH];
  logic [CNTW-1:0] count_d    [NCH];
  logic [NCH-1:0]  ovf_err_q, ovf_err_d;
  logic [NCH-1:0]  udf_err_q, udf_err_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic [CW-1:0]   data_ch_q, data_ch_d;

  logic [CW-1:0]   sel_c;
  logic            any_hit_c;
  logic [NCH-1:0]  pop_c;
  logic [NCH-1:0]  push_c;

  // Status decoded from registered occupancy
  for (genvar g = 0; g < NCH; g++) begin : g_status
    assign full[g]                = (count_q[g] == CNTW'(DEPTH));
    assign empty[g]               = (count_q[g] == '0);
    assign count[g*CNTW +: CNTW]  = count_q[g];
  end

  // Highest-index hit wins; lower hits are simply not serviced this cycle
  always_comb begin
    sel_c     = '0;
    any_hit_c = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) begin
        sel_c     = CW'(c);
        any_hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    pop_c        = '0;
    push_c       = '0;
    ovf_err_d    = ovf_err_q;
    udf_err_d    = udf_err_q;
    data_out_d   = data_out_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      count_d[c]  = count_q[c];
      if (flush[c]) begin
        wr_ptr_d[c]  = '0;
        rd_ptr_d[c]  = '0;
        count_d[c]   = '0;
        ovf_err_d[c] = 1'b0;
        udf_err_d[c] = 1'b0;
      end else begin
        pop_c[c]  = any_hit_c && (sel_c == CW'(c)) && !empty[c];
        push_c[c] = fill_valid[c] && (!full[c] || pop_c[c]);
        if (any_hit_c && (sel_c == CW'(c)) && empty[c]) udf_err_d[c] = 1'b1;
        if (fill_valid[c] && full[c] && !pop_c[c])       ovf_err_d[c] = 1'b1;
        if (push_c[c]) wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
        if (pop_c[c])  rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
        if (push_c[c] && !pop_c[c]) count_d[c] = count_q[c] + CNTW'(1);
        if (pop_c[c] && !push_c[c]) count_d[c] = count_q[c] - CNTW'(1);
      end
    end
    if (|pop_c) begin
      data_out_d   = mem_q[sel_c][rd_ptr_q[sel_c]];
      data_ch_d    = sel_c;
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      ovf_err_q    <= '0;
      udf_err_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_ch_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
      end
      ovf_err_q    <= ovf_err_d;
      udf_err_q    <= udf_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_ch_q    <= data_ch_d;
    end
  end

  // Storage is never reset; flush and reset only move pointers
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push_c[c] && !rst) mem_q[c][wr_ptr_q[c]] <= fill_data;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_ch    = data_ch_q;
  assign ovf_err    = ovf_err_q;
  assign udf_err    = udf_err_q;

endmodule

// File: tb/tb_prefetch_fifo_bank.sv
// Directed self-checking bench for prefetch_fifo_bank (DW=32, DEPTH=8, NCH=3).
module tb_prefetch_fifo_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fill_valid;
  logic [31:0] fill_data;
  logic [2:0]  hit;
  logic [2:0]  flush;
  logic [31:0] data_out;
  logic        data_valid;
  logic [1:0]  data_ch;
  logic [2:0]  full;
  logic [2:0]  empty;
  logic [11:0] count;
  logic [2:0]  ovf_err;
  logic [2:0]  udf_err;

  int n_checks = 0;
  int n_errors = 0;

  prefetch_fifo_bank dut (
    .clk(clk), .rst(rst), .fill_valid(fill_valid), .fill_data(fill_data),
    .hit(hit), .flush(flush), .data_out(data_out), .data_valid(data_valid),
    .data_ch(data_ch), .full(full), .empty(empty), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs, then sample #1 after the edge
  task automatic cyc(input logic [2:0] fv, input logic [31:0] fd,
                     input logic [2:0] h, input logic [2:0] fl);
    fill_valid = fv;
    fill_data  = fd;
    hit        = h;
    flush      = fl;
    @(posedge clk);
    #1;
    fill_valid = '0;
    hit        = '0;
    flush      = '0;
  endtask

  function automatic logic [3:0] cnt(input int c);
    return count[c*4 +: 4];
  endfunction

  logic [31:0] q[$];
  logic [31:0] exp_w;
  logic        popped;

  initial begin
    rst = 1'b1; fill_valid = '0; fill_data = '0; hit = '0; flush = '0;
    cyc('0, '0, '0, '0);
    cyc('0, '0, '0, '0);
    rst = 1'b0;
    check("rst_empty", 64'(empty), 64'h7);
    check("rst_full", 64'(full), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_dv", 64'(data_valid), 64'h0);
    check("rst_dout", 64'(data_out), 64'h0);
    check("rst_dch", 64'(data_ch), 64'h0);
    check("rst_err", 64'({ovf_err, udf_err}), 64'h0);

    // Fill ch0 to full, then drain in order
    for (int i = 0; i < 8; i++) cyc(3'b001, 32'hA0 + 32'(i), '0, '0);
    check("t1_full0", 64'(full[0]), 64'h1);
    check("t1_cnt0", 64'(cnt(0)), 64'h8);
    for (int i = 0; i < 8; i++) begin
      cyc('0, '0, 3'b001, '0);
      check("t1_dv", 64'(data_valid), 64'h1);
      check("t1_dout", 64'(data_out), 64'hA0 + 64'(i));
    end
    check("t1_empty0", 64'(empty[0]), 64'h1);
    check("t1_udf", 64'(udf_err), 64'h0);

    // ch1 overflow, then push+pop on full
    for (int i = 0; i < 8; i++) cyc(3'b010, 32'h10 + 32'(i), '0, '0);
    cyc(3'b010, 32'hDEAD, '0, '0);
    check("t2_ovf", 64'(ovf_err), 64'h2);
    check("t2_cnt1", 64'(cnt(1)), 64'h8);
    check("t2_dv_idle", 64'(data_valid), 64'h0);
    cyc(3'b010, 32'hBEEF, 3'b010, '0);
    check("t2_pp_dout", 64'(data_out), 64'h10);
    check("t2_pp_dch", 64'(data_ch), 64'h1);
    check("t2_pp_cnt1", 64'(cnt(1)), 64'h8);
    check("t2_pp_full", 64'(full[1]), 64'h1);
    for (int i = 1; i < 9; i++) begin
      cyc('0, '0, 3'b010, '0);
      check("t2_drain", 64'(data_out), (i == 8) ? 64'hBEEF : 64'h10 + 64'(i));
    end
    check("t2_empty1", 64'(empty[1]), 64'h1);

    // Underflow on ch2 with same-cycle fill: no bypass
    cyc(3'b100, 32'h55, 3'b100, '0);
    check("t3_dv", 64'(data_valid), 64'h0);
    check("t3_udf", 64'(udf_err), 64'h4);
    check("t3_hold", 64'(data_out), 64'hBEEF);
    check("t3_cnt2", 64'(cnt(2)), 64'h1);
    cyc('0, '0, 3'b100, '0);
    check("t3_dout", 64'(data_out), 64'h55);
    check("t3_dch", 64'(data_ch), 64'h2);

    // Priority: ch2 wins over ch0
    cyc(3'b100, 32'h99, '0, '0);
    cyc(3'b001, 32'h01, '0, '0);
    cyc(3'b001, 32'h02, '0, '0);
    cyc('0, '0, 3'b101, '0);
    check("t4_dout", 64'(data_out), 64'h99);
    check("t4_dch", 64'(data_ch), 64'h2);
    check("t4_cnt0", 64'(cnt(0)), 64'h2);
    check("t4_udf0", 64'(udf_err[0]), 64'h0);
    cyc('0, '0, 3'b001, '0);
    check("t4_ch0a", 64'(data_out), 64'h01);
    cyc('0, '0, 3'b001, '0);
    check("t4_ch0b", 64'(data_out), 64'h02);

    // Broadcast fill to ch0 and ch1
    cyc(3'b011, 32'h3C, '0, '0);
    check("t4_bc_cnt", 64'({cnt(1), cnt(0)}), 64'h11);
    cyc('0, '0, 3'b001, '0);
    check("t4_bc0", 64'(data_out), 64'h3C);
    cyc('0, '0, 3'b010, '0);
    check("t4_bc1", 64'({data_ch, data_out}), {30'd0, 2'd1, 32'h3C});

    // Flush ch1 with concurrent fill and hit
    for (int i = 0; i < 5; i++) cyc(3'b010, 32'h60 + 32'(i), '0, '0);
    check("t5_cnt_pre", 64'(cnt(1)), 64'h5);
    cyc(3'b010, 32'hEE, 3'b010, 3'b010);
    check("t5_cnt1", 64'(cnt(1)), 64'h0);
    check("t5_dv", 64'(data_valid), 64'h0);
    check("t5_err1", 64'({ovf_err[1], udf_err[1]}), 64'h0);
    check("t5_empty1", 64'(empty[1]), 64'h1);
    cyc(3'b010, 32'h77, '0, '0);
    cyc('0, '0, 3'b010, '0);
    check("t5_dout", 64'(data_out), 64'h77);

    // Interleaved push/pop on ch0 across the pointer wrap
    q.delete();
    for (int i = 0; i < 20; i++) begin
      logic       do_push;
      logic       do_pop;
      do_push = (i % 3) != 2;
      do_pop  = ((i % 2) == 1) && (q.size() > 0);
      popped  = 1'b0;
      if (do_pop) begin
        exp_w  = q.pop_front();
        popped = 1'b1;
      end
      if (do_push) q.push_back(32'hC0 + 32'(i));
      cyc(do_push ? 3'b001 : 3'b000, 32'hC0 + 32'(i), do_pop ? 3'b001 : 3'b000, '0);
      check("t6_dv", 64'(data_valid), 64'(popped));
      if (popped) check("t6_dout", 64'(data_out), 64'(exp_w));
      check("t6_cnt", 64'(cnt(0)), 64'(q.size()));
    end
    while (q.size() > 0) begin
      exp_w = q.pop_front();
      cyc('0, '0, 3'b001, '0);
      check("t6_drain", 64'(data_out), 64'(exp_w));
    end
    check("t6_empty0", 64'(empty[0]), 64'h1);
    check("t6_udf", 64'(udf_err[0]), 64'h0);

    // Reset drops buffered data and sticky flags
    cyc(3'b001, 32'h1234, '0, '0);
    rst = 1'b1;
    cyc('0, '0, '0, '0);
    rst = 1'b0;
    check("rst2_cnt", 64'(count), 64'h0);
    check("rst2_err", 64'({ovf_err, udf_err}), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
